can_frame_rx: RTL and testbench

CAN_FRAME_RX -- requirements
Module: can_frame_rx

---
 rtl/can_frame_rx.sv | 273 +++++++++++++++++++++++++++
 tb/tb_can_frame_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : can_frame_rx
// Purpose  : CAN 2.0A/2.0B frame receiver. Hard-syncs on SOF, samples at a
//            fixed point, destuffs, checks CRC-15 and the fixed-form fields,
//            drives ACK for good frames and reports fields in one DV pulse.
// Revision : 1.0 - initial release
// ============================================================================
module can_frame_rx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int SAMPLE_PT    = 6,
  parameter bit ACK_EN       = 1'b1
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_Serial,
  output logic        o_Tx_Ack,
  output logic        o_Rx_DV,
  output logic [28:0] o_Id,
  output logic        o_Ide,
  output logic        o_Rtr,
  output logic [3:0]  o_Dlc,
  output logic [63:0] o_Data,
  output logic        o_Err,
  output logic [1:0]  o_Err_Code,
  output logic        o_Busy
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SMP   = CNT_W'(SAMPLE_PT);
  localparam logic [14:0]      CRC_POLY  = 15'h4599;
  localparam logic [1:0]       ERR_STUFF = 2'b01;
  localparam logic [1:0]       ERR_CRC   = 2'b10;
  localparam logic [1:0]       ERR_FORM  = 2'b11;

  typedef enum logic [4:0] {
    ST_INTEGRATE, ST_IDLE, ST_SOF, ST_ID_A, ST_SRR_RTR, ST_IDE, ST_ID_B,
    ST_RTR, ST_R1, ST_R0, ST_DLC, ST_DATA, ST_CRC, ST_CRC_DEL, ST_ACK_SLOT,
    ST_ACK_DEL, ST_EOF
  } state_t;

  state_t           state_q;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       fld_cnt_q;
  logic [3:0]       int_cnt_q;
  logic [2:0]       run_q;
  logic             last_q;
  logic [14:0]      crc_q;
  logic [10:0]      id_a_q;
  logic [17:0]      id_b_q;
  logic             ide_q, rtr_q;
  logic [3:0]       dlc_q;
  logic [63:0]      data_q;
  logic             tx_ack_q, rx_dv_q, err_q, busy_q;
  logic [1:0]       err_code_q;
  logic [28:0]      out_id_q;
  logic             out_ide_q, out_rtr_q;
  logic [3:0]       out_dlc_q;
  logic [63:0]      out_data_q;

  logic        rx_s, sample_d, wrap_d, in_stuff_d, stuff_bit_d, data_last_d;
  logic        err_d;
  logic [1:0]  err_code_d;
  logic [14:0] crc_d;
  logic [3:0]  nbytes_d;

  assign rx_s        = sync2_q;
  assign sample_d    = (cnt_q == CNT_SMP);
  assign wrap_d      = (cnt_q == CNT_LAST);
  assign in_stuff_d  = state_q inside {ST_ID_A, ST_SRR_RTR, ST_IDE, ST_ID_B, ST_RTR,
                                       ST_R1, ST_R0, ST_DLC, ST_DATA, ST_CRC};
  assign stuff_bit_d = in_stuff_d && (run_q == 3'd5);
  assign crc_d       = {crc_q[13:0], 1'b0} ^ ((rx_s ^ crc_q[14]) ? CRC_POLY : 15'h0000);
  assign nbytes_d    = dlc_q[3] ? 4'd8 : dlc_q;
  assign data_last_d = ({1'b0, fld_cnt_q} == ({nbytes_d, 3'b000} - 7'd1));

  assign o_Tx_Ack   = tx_ack_q;
  assign o_Rx_DV    = rx_dv_q;
  assign o_Err      = err_q;
  assign o_Err_Code = err_code_q;
  assign o_Busy     = busy_q;
  assign o_Id       = out_id_q;
  assign o_Ide      = out_ide_q;
  assign o_Rtr      = out_rtr_q;
  assign o_Dlc      = out_dlc_q;
  assign o_Data     = out_data_q;

  // Two-flop synchroniser plus a delayed copy used for SOF edge detection
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= i_Rx_Serial;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Error decode for the current sample point; stuff errors take priority
  always_comb begin
    err_d      = 1'b0;
    err_code_d = 2'b00;
    if (sample_d) begin
      if (stuff_bit_d && (rx_s == last_q)) begin
        err_d = 1'b1; err_code_d = ERR_STUFF;
      end else if (state_q == ST_CRC_DEL && !rx_s) begin
        err_d = 1'b1; err_code_d = ERR_FORM;
      end else if (state_q == ST_ACK_DEL) begin
        if (crc_q != 15'h0000) begin
          err_d = 1'b1; err_code_d = ERR_CRC;
        end else if (!rx_s) begin
          err_d = 1'b1; err_code_d = ERR_FORM;
        end
      end else if (state_q == ST_EOF && !rx_s && fld_cnt_q < 6'd6) begin
        err_d = 1'b1; err_code_d = ERR_FORM;
      end
    end
  end

  // Bit timing, field sequencing, destuffing, CRC and registered outputs
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= ST_INTEGRATE;
      cnt_q      <= '0;
      fld_cnt_q  <= '0;
      int_cnt_q  <= '0;
      run_q      <= '0;
      last_q     <= 1'b0;
      crc_q      <= '0;
      id_a_q     <= '0;
      id_b_q     <= '0;
      ide_q      <= 1'b0;
      rtr_q      <= 1'b0;
      dlc_q      <= '0;
      data_q     <= '0;
      tx_ack_q   <= 1'b0;
      rx_dv_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      busy_q     <= 1'b0;
      out_id_q   <= '0;
      out_ide_q  <= 1'b0;
      out_rtr_q  <= 1'b0;
      out_dlc_q  <= '0;
      out_data_q <= '0;
    end else begin
      rx_dv_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= wrap_d ? '0 : cnt_q + CNT_W'(1);
      if (state_q == ST_IDLE) begin
        // Hard sync: the edge cycle counts as clock 0 of the SOF bit
        if (prev_q && !rx_s) begin
          cnt_q   <= CNT_W'(1);
          state_q <= ST_SOF;
          busy_q  <= 1'b1;
        end
      end else if (wrap_d) begin
        // ACK spans exactly the bit that follows CRC_DEL
        tx_ack_q <= ACK_EN && (state_q == ST_ACK_SLOT) && (crc_q == 15'h0000);
      end else if (sample_d) begin
        if (err_d) begin
          state_q    <= ST_INTEGRATE;
          int_cnt_q  <= '0;
          err_q      <= 1'b1;
          err_code_q <= err_code_d;
          busy_q     <= 1'b0;
          tx_ack_q   <= 1'b0;
        end else if (stuff_bit_d) begin
          last_q <= rx_s;
          run_q  <= 3'd1;
        end else begin
          if (in_stuff_d) begin
            run_q  <= (rx_s == last_q) ? run_q + 3'd1 : 3'd1;
            last_q <= rx_s;
            crc_q  <= crc_d;
          end
          fld_cnt_q <= fld_cnt_q + 6'd1;
          case (state_q)
            ST_INTEGRATE: begin
              if (!rx_s) int_cnt_q <= '0;
              else if (int_cnt_q == 4'd10) begin
                int_cnt_q <= '0;
                state_q   <= ST_IDLE;
              end else int_cnt_q <= int_cnt_q + 4'd1;
            end
            ST_SOF: begin
              if (rx_s) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= ST_ID_A;
                fld_cnt_q <= '0;
                run_q     <= 3'd1;
                last_q    <= 1'b0;
                crc_q     <= '0;
                data_q    <= '0;
                id_b_q    <= '0;
              end
            end
            ST_ID_A: begin
              id_a_q <= {id_a_q[9:0], rx_s};
              if (fld_cnt_q == 6'd10) state_q <= ST_SRR_RTR;
            end
            ST_SRR_RTR: begin
              rtr_q   <= rx_s;
              state_q <= ST_IDE;
            end
            ST_IDE: begin
              ide_q     <= rx_s;
              fld_cnt_q <= '0;
              state_q   <= rx_s ? ST_ID_B : ST_R0;
            end
            ST_ID_B: begin
              id_b_q <= {id_b_q[16:0], rx_s};
              if (fld_cnt_q == 6'd17) state_q <= ST_RTR;
            end
            ST_RTR: begin
              rtr_q   <= rx_s;
              state_q <= ST_R1;
            end
            ST_R1: state_q <= ST_R0;
            ST_R0: begin
              fld_cnt_q <= '0;
              state_q   <= ST_DLC;
            end
            ST_DLC: begin
              dlc_q <= {dlc_q[2:0], rx_s};
              if (fld_cnt_q == 6'd3) begin
                fld_cnt_q <= '0;
                state_q   <= (rtr_q || {dlc_q[2:0], rx_s} == 4'd0) ? ST_CRC : ST_DATA;
              end
            end
            ST_DATA: begin
              data_q[6'd63 - fld_cnt_q] <= rx_s;
              if (data_last_d) begin
                fld_cnt_q <= '0;
                state_q   <= ST_CRC;
              end
            end
            ST_CRC:      if (fld_cnt_q == 6'd14) state_q <= ST_CRC_DEL;
            ST_CRC_DEL:  state_q <= ST_ACK_SLOT;
            ST_ACK_SLOT: state_q <= ST_ACK_DEL;
            ST_ACK_DEL: begin
              fld_cnt_q <= '0;
              state_q   <= ST_EOF;
            end
            ST_EOF: begin
              // Bit 7 value is deliberately ignored
              if (fld_cnt_q == 6'd6) begin
                state_q    <= ST_IDLE;
                busy_q     <= 1'b0;
                rx_dv_q    <= 1'b1;
                err_code_q <= 2'b00;
                out_id_q   <= ide_q ? {id_a_q, id_b_q} : {18'd0, id_a_q};
                out_ide_q  <= ide_q;
                out_rtr_q  <= rtr_q;
                out_dlc_q  <= dlc_q;
                out_data_q <= data_q;
              end
            end
            default: state_q <= ST_INTEGRATE;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_can_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_frame_rx
// Purpose  : Scoreboard bench for can_frame_rx with a frame-building model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_can_frame_rx;

  localparam int CPB = 10;
  localparam int SP  = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        o_Tx_Ack, o_Rx_DV, o_Ide, o_Rtr, o_Err, o_Busy;
  logic [28:0] o_Id;
  logic [3:0]  o_Dlc;
  logic [63:0] o_Data;
  logic [1:0]  o_Err_Code;

  can_frame_rx #(.CLKS_PER_BIT(CPB), .SAMPLE_PT(SP), .ACK_EN(1'b1)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx),
    .o_Tx_Ack(o_Tx_Ack), .o_Rx_DV(o_Rx_DV), .o_Id(o_Id), .o_Ide(o_Ide),
    .o_Rtr(o_Rtr), .o_Dlc(o_Dlc), .o_Data(o_Data), .o_Err(o_Err),
    .o_Err_Code(o_Err_Code), .o_Busy(o_Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [28:0] id;
    bit          ide;
    bit          rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    int          ack;
  } exp_t;

  exp_t sb[$];
  exp_t last_ok;
  int   checks = 0;
  int   errors = 0;
  bit   drv_in_ack = 1'b0;
  int   ack_cnt = 0;
  bit   ack_prev = 1'b0;
  bit   raw[$];
  bit   bits[$];
  int   stuff_pos[$];
  int   tail;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- reference model: frame construction ----------------
  function automatic void push_raw(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) raw.push_back(v[i]);
  endfunction

  // CRC as remainder of M(x)*x^15 divided by the generator, by long division
  function automatic logic [14:0] crc_of_raw();
    logic [15:0] gen;
    logic [14:0] r;
    bit          w[$];
    gen = 16'hC599;
    w = raw;
    for (int i = 0; i < 15; i++) w.push_back(1'b0);
    for (int i = 0; i < raw.size(); i++)
      if (w[i]) for (int j = 0; j < 16; j++) w[i+j] = w[i+j] ^ gen[15-j];
    r = '0;
    for (int i = 0; i < 15; i++) r = {r[13:0], w[raw.size()+i]};
    return r;
  endfunction

  function automatic int nbytes(input logic [3:0] dlc);
    return (dlc > 4'd8) ? 8 : int'(dlc);
  endfunction

  function automatic void build(input exp_t e, input int flip_crc);
    logic [14:0] c;
    int          run;
    bit          prev;
    raw.delete(); bits.delete(); stuff_pos.delete();
    raw.push_back(1'b0);
    if (!e.ide) begin
      push_raw(64'(e.id[10:0]), 11);
      raw.push_back(e.rtr); raw.push_back(1'b0); raw.push_back(1'b0);
    end else begin
      push_raw(64'(e.id[28:18]), 11);
      raw.push_back(1'b1); raw.push_back(1'b1);
      push_raw(64'(e.id[17:0]), 18);
      raw.push_back(e.rtr); raw.push_back(1'b0); raw.push_back(1'b0);
    end
    push_raw(64'(e.dlc), 4);
    if (!e.rtr) for (int i = 0; i < 8 * nbytes(e.dlc); i++) raw.push_back(e.data[63-i]);
    c = crc_of_raw();
    if (flip_crc >= 0) c[flip_crc] = ~c[flip_crc];
    push_raw(64'(c), 15);
    run = 0; prev = 1'b0;
    for (int i = 0; i < raw.size(); i++) begin
      bits.push_back(raw[i]);
      run  = (i > 0 && raw[i] == prev) ? run + 1 : 1;
      prev = raw[i];
      if (run == 5 && i < raw.size() - 1) begin
        stuff_pos.push_back(bits.size());
        bits.push_back(!prev);
        prev = !prev;
        run  = 1;
      end
    end
    tail = bits.size();
    for (int i = 0; i < 10; i++) bits.push_back(1'b1);
  endfunction

  function automatic exp_t ok_exp(input exp_t e);
    exp_t x;
    x = e;
    x.is_err = 1'b0; x.code = 2'b00; x.ack = CPB;
    x.id   = e.ide ? e.id : {18'd0, e.id[10:0]};
    x.data = e.rtr ? 64'd0 : (e.data & (~64'd0 << (64 - 8 * nbytes(e.dlc))));
    return x;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive_bit(input bit b, input bit ack_slot);
    @(posedge clk); #1;
    rx = b;
    drv_in_ack = ack_slot;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic drive_frame(input int idle_bits);
    for (int i = 0; i < bits.size(); i++) drive_bit(bits[i], i == tail + 1);
    for (int i = 0; i < idle_bits; i++) drive_bit(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'({o_Tx_Ack, o_Rx_DV, o_Id, o_Ide, o_Rtr, o_Dlc, o_Data,
                               o_Err, o_Err_Code, o_Busy}), 128'd0);
    last_ok = '{default: 0};
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic exp_t mk(input logic [28:0] id, input bit ide, input bit rtr,
                              input logic [3:0] dlc, input logic [63:0] data);
    exp_t e;
    e = '{default: 0};
    e.id = id; e.ide = ide; e.rtr = rtr; e.dlc = dlc; e.data = data;
    return e;
  endfunction

  task automatic send_ok(input exp_t e);
    build(e, -1);
    sb.push_back(ok_exp(e));
    drive_frame(13);
  endtask

  task automatic rand_frame();
    exp_t e, x;
    int   kind;
    e = mk(29'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), {$urandom, $urandom});
    kind = $urandom_range(0, 9);
    build(e, (kind == 2) ? $urandom_range(0, 14) : -1);
    x = ok_exp(e);
    case (kind)
      2: begin x.is_err = 1'b1; x.code = 2'b10; x.ack = 0; end
      3: if (stuff_pos.size() > 0) begin
           bits[stuff_pos[$urandom_range(0, stuff_pos.size() - 1)]] ^= 1'b1;
           x.is_err = 1'b1; x.code = 2'b01; x.ack = 0;
         end
      4: begin bits[tail] = 1'b0; x.is_err = 1'b1; x.code = 2'b11; x.ack = 0; end
      5: begin bits[tail+2] = 1'b0; x.is_err = 1'b1; x.code = 2'b11; end
      6: begin bits[tail+3+$urandom_range(0, 5)] = 1'b0; x.is_err = 1'b1; x.code = 2'b11; end
      7: bits[tail+9] = 1'b0;
      default: ;
    endcase
    sb.push_back(x);
    drive_frame(13);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ack_cnt = 0;
    end else begin
      if (o_Tx_Ack && !ack_prev) chk("ack_in_slot", 128'(drv_in_ack), 128'd1);
      if (o_Tx_Ack) ack_cnt++;
      if (o_Rx_DV && o_Err) chk("dv_and_err_together", 128'd1, 128'd0);
      else if (o_Rx_DV || o_Err) begin
        if (sb.size() == 0) chk("unexpected_event", 128'({o_Rx_DV, o_Err}), 128'd0);
        else begin
          e = sb.pop_front();
          chk("event_is_err", 128'(o_Err), 128'(e.is_err));
          chk("ack_cycles", 128'(ack_cnt), 128'(e.ack));
          if (o_Err) begin
            chk("err_code", 128'(o_Err_Code), 128'(e.code));
            chk("fields_held_on_err", 128'({o_Id, o_Ide, o_Rtr, o_Dlc, o_Data}),
                128'({last_ok.id, last_ok.ide, last_ok.rtr, last_ok.dlc, last_ok.data}));
          end else begin
            chk("id", 128'(o_Id), 128'(e.id));
            chk("ide", 128'(o_Ide), 128'(e.ide));
            chk("rtr", 128'(o_Rtr), 128'(e.rtr));
            chk("dlc", 128'(o_Dlc), 128'(e.dlc));
            chk("data", 128'(o_Data), 128'(e.data));
            last_ok = e;
          end
        end
        ack_cnt = 0;
      end
    end
    ack_prev = o_Tx_Ack;
  end

  // ---------------- test sequence ----------------
  initial begin
    exp_t e, x;
    last_ok = '{default: 0};
    do_reset();
    for (int i = 0; i < 13; i++) drive_bit(1'b1, 1'b0);

    send_ok(mk(29'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000));
    send_ok(mk(29'h1ABCDEF0, 1'b1, 1'b1, 4'd4, 64'hDEAD_BEEF_0123_4567));
    send_ok(mk(29'h000, 1'b0, 1'b0, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF));
    send_ok(mk(29'h7FF, 1'b0, 1'b0, 4'd12, 64'h0123_4567_89AB_CDEF));

    // Six dominant bits at the start of ID_A
    e = mk(29'h000, 1'b0, 1'b0, 4'd1, 64'h3C00_0000_0000_0000);
    build(e, -1);
    bits[stuff_pos[0]] = 1'b0;
    x = ok_exp(e); x.is_err = 1'b1; x.code = 2'b01; x.ack = 0;
    sb.push_back(x);
    drive_frame(13);
    send_ok(mk(29'h0AB, 1'b0, 1'b0, 4'd3, 64'h1122_3300_0000_0000));

    // One CRC bit flipped, then a dominant EOF bit 3
    e = mk(29'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000);
    build(e, 7);
    x = ok_exp(e); x.is_err = 1'b1; x.code = 2'b10; x.ack = 0;
    sb.push_back(x);
    drive_frame(13);
    build(e, -1);
    bits[tail+5] = 1'b0;
    x = ok_exp(e); x.is_err = 1'b1; x.code = 2'b11;
    sb.push_back(x);
    drive_frame(13);

    // Reset in the data field, then an SOF after too few idle bits
    e = mk(29'h321, 1'b0, 1'b0, 4'd8, 64'h0F0F_0F0F_0F0F_0F0F);
    build(e, -1);
    for (int i = 0; i < 28; i++) drive_bit(bits[i], 1'b0);
    @(negedge clk);
    chk("busy_mid_frame", 128'(o_Busy), 128'd1);
    do_reset();
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
    drive_frame(13);
    send_ok(e);

    for (int n = 0; n < 24; n++) rand_frame();

    repeat (20) @(posedge clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
